// File: rtl/ustc_psum_drain.sv
// ustc_psum_drain: captures a complete M x N partial-sum matrix and streams
// it out one row per accepted transfer. Supports back-to-back capture on the
// final row's transfer, so a continuous stream drains with no bubble cycles.
// A matrix offered while busy is dropped and latched into a sticky overrun flag.
module ustc_psum_drain #(
   parameter int M       = 16,
   parameter int N       = 16,
   parameter int DW_DATA = 8,
   parameter int DW_ROW  = 4,
   localparam int DW_OUT  = M * N * DW_DATA,
   localparam int DW_LINE = N * DW_DATA
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [DW_OUT-1:0]  in,
   output logic               in_ready,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [DW_LINE-1:0] out,
   output logic [DW_ROW-1:0]  out_row,
   output logic               out_last,
   output logic               overrun
);

   typedef enum logic {
      IDLE,
      DRAIN
   } state_t;

   state_t              state, state_nxt;
   logic [DW_ROW-1:0]   cnt, cnt_nxt;
   logic [DW_OUT-1:0]   mat_q;
   logic                last_row;
   logic                xfer;
   logic                capture;
   logic                drop;

   // Handshake decode: ready in IDLE, or when the final row leaves this cycle.
   always_comb begin
      last_row = (cnt == DW_ROW'(M - 1));
      xfer     = (state == DRAIN) && out_ready;
      in_ready = (state == IDLE) || (xfer && last_row);
      capture  = in_valid && in_ready;
      drop     = in_valid && !in_ready;
   end

   // Next-state and row-counter logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = DRAIN;
               cnt_nxt   = '0;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (last_row) begin
                  // counter returns to 0 either way: restart on a new matrix,
                  // or park at 0 in IDLE so out_row reads 0 when idle
                  cnt_nxt = '0;
                  if (!in_valid) begin
                     state_nxt = IDLE;
                  end
               end else begin
                  cnt_nxt = cnt + DW_ROW'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Control state register with synchronous reset; overrun is sticky.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         overrun <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (drop) begin
            overrun <= 1'b1;
         end
      end
   end

   // Matrix buffer: loaded only on an accepted matrix, contents free after reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         mat_q <= in;
      end
   end

   // Row presentation; buffer contents are masked while no row is valid.
   always_comb begin
      out_valid = (state == DRAIN);
      out_row   = cnt;
      out_last  = out_valid && last_row;
      out       = '0;
      if (out_valid) begin
         out = mat_q[int'(cnt) * DW_LINE +: DW_LINE];
      end
   end

endmodule
